tstate_seq: RTL

TSTATE_SEQ -- requirements
Module: tstate_seq

---
 rtl/sap_pkg.sv | 7 +
 rtl/tstate_seq_sync_edge.sv | 23 ++
 rtl/tstate_seq.sv | 91 +++++++++
 3 files changed

// File: rtl/sap_pkg.sv
// Shared definitions for the T-state sequencer: control states and ring constants.
package sap_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_ARMED, ST_RUN, ST_HALTED} seq_state_t;

  localparam int         NSTATES_DEF = 6;
  localparam logic [7:0] T1_ONEHOT   = 8'h01;
endpackage

// File: rtl/tstate_seq_sync_edge.sv
// Two-flop synchronizer followed by an edge register; o_rise is high for one clock per input rise.
module sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic i_async,
  output logic o_rise
);
  logic r_s1, r_s2, r_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_d  <= 1'b0;
    end else begin
      r_s1 <= i_async;
      r_s2 <= r_s1;
      r_d  <= r_s2;
    end
  end

  assign o_rise = r_s2 & ~r_d;
endmodule

// File: rtl/tstate_seq.sv
// Machine-cycle T-state sequencer: one-hot T-state ring advanced by clken under a
// free-run / single-step / halt control FSM, with a trailing latch strobe on clken2.
module tstate_seq
  import sap_pkg::*;
#(
  parameter int NSTATES = NSTATES_DEF,
  parameter int CNTW    = 16
) (
  input  logic               sysclk,
  input  logic               reset,
  input  logic               clken,
  input  logic               clken2,
  input  logic               run_mode,
  input  logic               step_btn,
  input  logic               halt,
  input  logic               cycle_done,
  output logic [NSTATES-1:0] tstate,
  output logic               tick,
  output logic               latch,
  output logic               halted,
  output logic [CNTW-1:0]    cycle_count
);
  localparam logic [NSTATES-1:0] L_T1 = T1_ONEHOT[NSTATES-1:0];

  seq_state_t         r_state, w_next;
  logic [NSTATES-1:0] r_tstate;
  logic [CNTW-1:0]    r_cnt;
  logic               r_tick, r_latch, r_pend;
  logic               w_step, w_adv, w_latch_fire;

  sync_edge u_step (
    .clk     (sysclk),
    .rst     (reset),
    .i_async (step_btn),
    .o_rise  (w_step)
  );

  assign w_adv        = clken & ((r_state == ST_RUN) | (r_state == ST_ARMED));
  // clken wins over a coincident clken2, so the strobe only fires on a clken-free cycle
  assign w_latch_fire = clken2 & ~clken & r_pend;

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (run_mode)    w_next = ST_RUN;
        else if (w_step) w_next = ST_ARMED;
      end
      ST_ARMED: begin
        if (w_adv) w_next = halt ? ST_HALTED : ST_IDLE;
      end
      ST_RUN: begin
        if (w_adv && halt)           w_next = ST_HALTED;
        else if (!w_adv && !run_mode) w_next = ST_IDLE;
      end
      ST_HALTED: w_next = ST_HALTED;
      default:   w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_tstate <= L_T1;
      r_cnt    <= '0;
      r_tick   <= 1'b0;
      r_latch  <= 1'b0;
      r_pend   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_tick  <= w_adv;
      r_latch <= w_latch_fire;
      if (w_adv)             r_pend <= 1'b1;
      else if (w_latch_fire) r_pend <= 1'b0;
      if (w_adv) begin
        if (r_tstate[NSTATES-1] | cycle_done) begin
          r_tstate <= L_T1;
          r_cnt    <= r_cnt + 1'b1;
        end else begin
          r_tstate <= {r_tstate[NSTATES-2:0], 1'b0};
        end
      end
    end
  end

  assign tstate      = r_tstate;
  assign cycle_count = r_cnt;
  assign tick        = r_tick;
  assign latch       = r_latch;
  assign halted      = (r_state == ST_HALTED);
endmodule
